// File: rtl/muxfullparalell_generic.sv
// muxfullparalell_generic: full-parallel N:1 mux (one-hot decode, AND-OR), optional output register.
// Define MUXFULLPARALELL_OUTPUT_REG_EN to register O on iClock with synchronous reset to 0.
module muxfullparalell_generic #(
  parameter int SIZE     = 8,
  parameter int SEL_BITS = 4
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [SEL_BITS-1:0] Sel,
  input  logic [SIZE-1:0]     I0,
  input  logic [SIZE-1:0]     I1,
  input  logic [SIZE-1:0]     I2,
  input  logic [SIZE-1:0]     I3,
  input  logic [SIZE-1:0]     I4,
  input  logic [SIZE-1:0]     I5,
  input  logic [SIZE-1:0]     I6,
  input  logic [SIZE-1:0]     I7,
  input  logic [SIZE-1:0]     I8,
  input  logic [SIZE-1:0]     I9,
  input  logic [SIZE-1:0]     I10,
  input  logic [SIZE-1:0]     I11,
  input  logic [SIZE-1:0]     I12,
  input  logic [SIZE-1:0]     I13,
  input  logic [SIZE-1:0]     I14,
  input  logic [SIZE-1:0]     I15,
  output logic [SIZE-1:0]     O
);
  localparam int N = 1 << SEL_BITS;
  generate
    if (SEL_BITS < 2 || SEL_BITS > 4) begin : g_bad_sel_bits
      $error("muxfullparalell_generic: SEL_BITS must be 2, 3 or 4");
    end
  endgenerate
  logic [SIZE-1:0] data [16];
  logic [N-1:0]    hot;
  logic [SIZE-1:0] mux;
  assign data = '{I0, I1, I2, I3, I4, I5, I6, I7, I8, I9, I10, I11, I12, I13, I14, I15};
  // An X/Z select matches no index, so hot stays zero and O resolves to zero.
  always_comb begin
    hot = '0;
    for (int k = 0; k < N; k++)
      if (Sel == SEL_BITS'(k)) hot[k] = 1'b1;
  end
  always_comb begin
    mux = '0;
    for (int k = 0; k < N; k++)
      mux = mux | (data[k] & {SIZE{hot[k]}});
  end
`ifdef MUXFULLPARALELL_OUTPUT_REG_EN
  always_ff @(posedge iClock)
    O <= iReset ? '0 : mux;
`else
  logic unused;
  assign unused = ^{iClock, iReset};
  assign O = mux;
`endif
endmodule

// File: tb/tb_muxfullparalell_generic.sv
// tb_muxfullparalell_generic: directed checks of the full-parallel mux in 4-, 3- and 2-bit select configurations.
module tb_muxfullparalell_generic;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sel4 = '0;
  logic [2:0] sel3 = '0;
  logic [1:0] sel2 = '0;
  logic [7:0] d4 [16];
  logic [7:0] d3 [16];
  logic [7:0] d2 [16];
  logic [7:0] o4, o3, o2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  muxfullparalell_generic #(.SIZE(8), .SEL_BITS(4)) u4 (
    .iClock(clk), .iReset(rst), .Sel(sel4),
    .I0(d4[0]), .I1(d4[1]), .I2(d4[2]), .I3(d4[3]), .I4(d4[4]), .I5(d4[5]), .I6(d4[6]), .I7(d4[7]),
    .I8(d4[8]), .I9(d4[9]), .I10(d4[10]), .I11(d4[11]), .I12(d4[12]), .I13(d4[13]), .I14(d4[14]), .I15(d4[15]),
    .O(o4));
  muxfullparalell_generic #(.SIZE(8), .SEL_BITS(3)) u3 (
    .iClock(clk), .iReset(rst), .Sel(sel3),
    .I0(d3[0]), .I1(d3[1]), .I2(d3[2]), .I3(d3[3]), .I4(d3[4]), .I5(d3[5]), .I6(d3[6]), .I7(d3[7]),
    .I8(d3[8]), .I9(d3[9]), .I10(d3[10]), .I11(d3[11]), .I12(d3[12]), .I13(d3[13]), .I14(d3[14]), .I15(d3[15]),
    .O(o3));
  muxfullparalell_generic #(.SIZE(8), .SEL_BITS(2)) u2 (
    .iClock(clk), .iReset(rst), .Sel(sel2),
    .I0(d2[0]), .I1(d2[1]), .I2(d2[2]), .I3(d2[3]), .I4(d2[4]), .I5(d2[5]), .I6(d2[6]), .I7(d2[7]),
    .I8(d2[8]), .I9(d2[9]), .I10(d2[10]), .I11(d2[11]), .I12(d2[12]), .I13(d2[13]), .I14(d2[14]), .I15(d2[15]),
    .O(o2));
`ifdef MUXFULLPARALELL_OUTPUT_REG_EN
  task automatic test_reset;
    rst = 1'b1;
    sel4 = 4'h3;
    d4[3] = 8'h5C;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o4 !== 8'h00) begin errors++; $display("FAIL reset_two_edges got %h want 00", o4); end
  endtask
  task automatic test_release;
    @(negedge clk);
    rst = 1'b0;
    sel4 = 4'h7;
    d4[7] = 8'hE4;
    #1;
    checks++;
    if (o4 !== 8'h00) begin errors++; $display("FAIL release_before_edge got %h want 00", o4); end
    @(posedge clk);
    #1;
    checks++;
    if (o4 !== 8'hE4) begin errors++; $display("FAIL release_after_edge got %h want e4", o4); end
  endtask
  task automatic test_sweep_registered;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sel4 = 4'(k);
      d4[k] = 8'h10 + 8'(k);
      #1;
      checks++;
      if (k > 0 && o4 !== 8'h10 + 8'(k - 1) + ((k - 1 == 7) ? 8'h00 : 8'h00)) begin
        if (!(k == 1 && o4 === 8'hE4)) begin errors++; $display("FAIL reg_hold sel=%0d got %h want %h", k, o4, 8'h10 + 8'(k - 1)); end
      end
      @(posedge clk);
      #1;
      checks++;
      if (o4 !== 8'h10 + 8'(k)) begin errors++; $display("FAIL reg_sweep sel=%0d got %h want %h", k, o4, 8'h10 + 8'(k)); end
    end
  endtask
  task automatic test_midstream_reset;
    @(negedge clk);
    rst = 1'b1;
    sel4 = 4'h9;
    @(posedge clk);
    #1;
    checks++;
    if (o4 !== 8'h00) begin errors++; $display("FAIL mid_reset got %h want 00", o4); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o4 !== 8'h19) begin errors++; $display("FAIL mid_reset_resume got %h want 19", o4); end
  endtask
`else
  task automatic test_reset;
    rst = 1'b1;
    sel4 = 4'h5;
    d4[5] = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o4 !== 8'h3C) begin errors++; $display("FAIL reset_ignored got %h want 3c", o4); end
    rst = 1'b0;
  endtask
  task automatic test_sweep4;
    for (int k = 0; k < 16; k++) d4[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 16; k++) begin
      sel4 = 4'(k);
      #1;
      checks++;
      if (o4 !== 8'h10 + 8'(k)) begin errors++; $display("FAIL sweep4 sel=%0d got %h want %h", k, o4, 8'h10 + 8'(k)); end
    end
  endtask
  task automatic test_sweep3;
    for (int k = 0; k < 16; k++) d3[k] = (k < 8) ? 8'hA0 + 8'(k) : 8'hFF;
    for (int k = 0; k < 8; k++) begin
      sel3 = 3'(k);
      #1;
      checks++;
      if (o3 !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL sweep3 sel=%0d got %h want %h", k, o3, 8'hA0 + 8'(k)); end
    end
  endtask
  task automatic test_ignored;
    sel3 = 3'h6;
    for (int k = 8; k < 16; k++) begin
      d3[k] = 8'(k * 17);
      d3[k - 8] = (k - 8 == 6) ? 8'hA6 : d3[k - 8];
      #1;
      checks++;
      if (o3 !== 8'hA6) begin errors++; $display("FAIL ignored3 i=%0d got %h want a6", k, o3); end
    end
  endtask
  task automatic test_sel2;
    d2[0] = 8'h11; d2[1] = 8'h22; d2[2] = 8'h33; d2[3] = 8'h44;
    for (int k = 4; k < 16; k++) d2[k] = 8'hEE;
    sel2 = 2'b10;
    #1;
    checks++;
    if (o2 !== 8'h33) begin errors++; $display("FAIL sel2 got %h want 33", o2); end
    d2[2] = 8'h5A;
    #1;
    checks++;
    if (o2 !== 8'h5A) begin errors++; $display("FAIL sel2_data_change got %h want 5a", o2); end
    sel2 = 2'b11;
    d2[3] = 8'h77;
    #1;
    checks++;
    if (o2 !== 8'h77) begin errors++; $display("FAIL sel2_joint_change got %h want 77", o2); end
  endtask
  task automatic test_lcd;
    sel4 = 4'h0; d4[0] = 8'h91;
    #1;
    checks++;
    if (o4 !== 8'h91) begin errors++; $display("FAIL lcd_sel0 got %h want 91", o4); end
    sel4 = 4'h4; d4[4] = 8'h90;
    #1;
    checks++;
    if (o4 !== 8'h90) begin errors++; $display("FAIL lcd_sel4 got %h want 90", o4); end
    d4[12] = 8'h00; d4[13] = 8'hFF; d4[11] = 8'hFF;
    sel4 = 4'hC;
    #1;
    checks++;
    if (o4 !== 8'h00) begin errors++; $display("FAIL lcd_selc got %h want 00", o4); end
  endtask
  task automatic test_x_sel;
    for (int k = 0; k < 16; k++) d4[k] = 8'h00;
    d4[15] = 8'hFF;
    d4[0] = 8'h00;
    sel4 = 4'bxxxx;
    #1;
    checks++;
    if (o4 !== 8'h00) begin errors++; $display("FAIL x_sel got %h want 00", o4); end
  endtask
`endif
  initial begin
    for (int k = 0; k < 16; k++) begin d4[k] = '0; d3[k] = '0; d2[k] = '0; end
`ifdef MUXFULLPARALELL_OUTPUT_REG_EN
    test_reset;
    test_release;
    test_sweep_registered;
    test_midstream_reset;
`else
    test_reset;
    test_sweep4;
    test_sweep3;
    test_ignored;
    test_sel2;
    test_lcd;
    test_x_sel;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
